// File: rtl/calc_seq_if.sv
// Key strobes, ALU handshake and status bundle of the calculator sequencer.
// The sequencer is the slave; the keypad/ALU environment is the master.
interface calc_seq_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       op_valid;
  logic [3:0] op_sel;
  logic       eq_valid;
  logic       clr_valid;
  logic [3:0] alu_op;
  logic [3:0] alu_data1;
  logic [3:0] alu_data2;
  logic       alu_busy;
  logic [7:0] alu_o;
  logic [7:0] result;
  logic       result_valid;
  logic       err;
  logic       seq_busy;

  modport master (
    output digit_valid, digit, op_valid, op_sel, eq_valid, clr_valid, alu_busy, alu_o,
    input  alu_op, alu_data1, alu_data2, result, result_valid, err, seq_busy
  );

  modport slave (
    input  digit_valid, digit, op_valid, op_sel, eq_valid, clr_valid, alu_busy, alu_o,
    output alu_op, alu_data1, alu_data2, result, result_valid, err, seq_busy
  );
endinterface

// File: rtl/calc_seq.sv
// Calculator key sequencer: collects A, operator and B, issues the operation
// to an external ALU, follows its busy handshake and captures the result.
module calc_seq (
  input  logic       clk,
  input  logic       rst,
  calc_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_CAP   = 3'd3,
    S_WHI   = 3'd4,
    S_WLO   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_STOP = 4'b0000;

  function automatic logic op_legal(input logic [3:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_op;
  logic [7:0] r_res;
  logic       r_b_set;
  logic       r_res_valid;
  logic       r_err;
  logic [1:0] r_tmo;

  logic       w_eq;
  logic       w_op;
  logic       w_dig;
  logic       w_busy;
  logic [3:0] w_alu_op;

  // Strobe priority eq > op > digit; an illegal op code still masks a digit.
  assign w_eq  = bus.eq_valid;
  assign w_op  = !bus.eq_valid && bus.op_valid && op_legal(bus.op_sel);
  assign w_dig = !bus.eq_valid && !bus.op_valid && bus.digit_valid;

  always_ff @(posedge clk) begin
    if (rst || bus.clr_valid) begin
      r_state     <= S_A;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_op        <= 4'd0;
      r_res       <= 8'd0;
      r_b_set     <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_tmo       <= 2'd0;
    end else begin
      case (r_state)
        S_A: begin
          if (w_op) begin
            r_op    <= bus.op_sel;
            r_b_set <= 1'b0;
            r_state <= S_B;
          end else if (w_dig) begin
            r_a <= bus.digit;
          end
        end
        S_B: begin
          if (w_eq && r_b_set) begin
            // Divide by zero is refused here so the ALU never sees it.
            if (r_op == OP_DIV && r_b == 4'd0) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (w_op) begin
            r_op <= bus.op_sel;
          end else if (w_dig) begin
            r_b     <= bus.digit;
            r_b_set <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_tmo   <= 2'd0;
          r_state <= (r_op == OP_ADD || r_op == OP_SUB) ? S_CAP : S_WHI;
        end
        S_CAP: begin
          r_res       <= bus.alu_o;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_WHI: begin
          if (bus.alu_busy) begin
            r_state <= S_WLO;
          end else if (r_tmo == 2'd2) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 2'd1;
          end
        end
        S_WLO: begin
          if (!bus.alu_busy) begin
            r_res       <= bus.alu_o;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // An operator here chains the previous result into operand A.
          if (w_op) begin
            r_a         <= r_res[3:0];
            r_op        <= bus.op_sel;
            r_b         <= 4'd0;
            r_b_set     <= 1'b0;
            r_res_valid <= 1'b0;
            r_state     <= S_B;
          end else if (w_dig) begin
            r_a         <= bus.digit;
            r_b         <= 4'd0;
            r_b_set     <= 1'b0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= S_A;
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  // alu_op drops in the same cycle busy falls so the ALU cannot restart.
  always_comb begin
    w_alu_op = OP_STOP;
    w_busy   = 1'b0;
    case (r_state)
      S_ISSUE: begin w_alu_op = r_op; w_busy = 1'b1; end
      S_CAP:   begin w_alu_op = OP_STOP; w_busy = 1'b1; end
      S_WHI:   begin w_alu_op = r_op; w_busy = 1'b1; end
      S_WLO:   begin w_alu_op = bus.alu_busy ? r_op : OP_STOP; w_busy = 1'b1; end
      default: begin w_alu_op = OP_STOP; w_busy = 1'b0; end
    endcase
  end

  assign bus.alu_op       = w_alu_op;
  assign bus.alu_data1    = r_a;
  assign bus.alu_data2    = r_b;
  assign bus.result       = r_res;
  assign bus.result_valid = r_res_valid;
  assign bus.err          = r_err;
  assign bus.seq_busy     = w_busy;
endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: ALU model, phase-level calculator model checked every
// cycle, directed scenarios with literal expectations, then random keys.
module tb_calc_seq;
  logic clk;
  logic rst;
  calc_seq_if bus();

  calc_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU model: add/sub answer next cycle; mul/div raise busy for alu_len cycles.
  logic alu_dead;
  int   alu_len;
  int   alu_cnt;
  int   alu_starts = 0;
  logic [7:0] alu_res;
  always @(posedge clk) begin
    if (rst) begin
      bus.alu_busy <= 1'b0;
      bus.alu_o    <= 8'h00;
      alu_cnt      <= 0;
    end else if (bus.alu_busy) begin
      if (alu_cnt <= 1) begin
        bus.alu_busy <= 1'b0;
        bus.alu_o    <= alu_res;
      end
      alu_cnt <= alu_cnt - 1;
    end else begin
      case (bus.alu_op)
        4'b1000: bus.alu_o <= 8'(bus.alu_data1) + 8'(bus.alu_data2);
        4'b0100: bus.alu_o <= 8'(bus.alu_data1) - 8'(bus.alu_data2);
        4'b0010, 4'b0001: begin
          if (!alu_dead) begin
            bus.alu_busy <= 1'b1;
            alu_cnt      <= alu_len;
            alu_starts   <= alu_starts + 1;
            if (bus.alu_op == 4'b0010) alu_res <= 8'(bus.alu_data1) * 8'(bus.alu_data2);
            else if (bus.alu_data2 == 4'd0) alu_res <= 8'hFF;
            else alu_res <= 8'(bus.alu_data1) / 8'(bus.alu_data2);
          end
        end
        default: ;
      endcase
    end
  end

  // Operator-cycle counters seen on the ALU port.
  int cnt_add = 0;
  int cnt_mul = 0;
  int cnt_div = 0;
  always @(negedge clk) begin
    if (bus.alu_op == 4'b1000) cnt_add <= cnt_add + 1;
    if (bus.alu_op == 4'b0010) cnt_mul <= cnt_mul + 1;
    if (bus.alu_op == 4'b0001) cnt_div <= cnt_div + 1;
  end

  // Behavioural calculator: key phases plus a computation tracker.
  typedef enum int {PH_A, PH_B, PH_CALC, PH_DONE} ph_t;
  ph_t m_ph;
  int  m_a, m_b, m_op, m_res, m_k, m_idle;
  bit  m_bset, m_rv, m_err, m_seen;
  bit  m_live = 1'b0;

  function automatic bit legal(input int c);
    return (c == 8) || (c == 4) || (c == 2) || (c == 1);
  endfunction

  function automatic int exp_alu_op();
    if (m_ph != PH_CALC) return 0;
    if (m_k == 0) return m_op;
    if (m_op == 8 || m_op == 4) return 0;
    if (!m_seen) return m_op;
    return bus.alu_busy ? m_op : 0;
  endfunction

  always @(posedge clk) begin
    if (rst || bus.clr_valid) begin
      if (rst) m_live <= 1'b1;
      m_ph <= PH_A; m_a <= 0; m_b <= 0; m_op <= 0; m_res <= 0;
      m_bset <= 1'b0; m_rv <= 1'b0; m_err <= 1'b0;
    end else begin
      case (m_ph)
        PH_A: begin
          if (bus.eq_valid) begin end
          else if (bus.op_valid) begin
            if (legal(int'(bus.op_sel))) begin
              m_op <= int'(bus.op_sel); m_bset <= 1'b0; m_ph <= PH_B;
            end
          end else if (bus.digit_valid) m_a <= int'(bus.digit);
        end
        PH_B: begin
          if (bus.eq_valid) begin
            if (m_bset && m_op == 1 && m_b == 0) begin
              m_err <= 1'b1; m_ph <= PH_DONE;
            end else if (m_bset) begin
              m_ph <= PH_CALC; m_k <= 0; m_seen <= 1'b0; m_idle <= 0;
            end
          end else if (bus.op_valid) begin
            if (legal(int'(bus.op_sel))) m_op <= int'(bus.op_sel);
          end else if (bus.digit_valid) begin
            m_b <= int'(bus.digit); m_bset <= 1'b1;
          end
        end
        PH_CALC: begin
          if (m_k == 0) m_k <= 1;
          else if (m_op == 8 || m_op == 4) begin
            m_res <= int'(bus.alu_o); m_rv <= 1'b1; m_ph <= PH_DONE;
          end else if (!m_seen) begin
            if (bus.alu_busy) m_seen <= 1'b1;
            else if (m_idle + 1 == 3) begin m_err <= 1'b1; m_ph <= PH_DONE; end
            else m_idle <= m_idle + 1;
          end else if (!bus.alu_busy) begin
            m_res <= int'(bus.alu_o); m_rv <= 1'b1; m_ph <= PH_DONE;
          end
        end
        default: begin
          if (bus.eq_valid) begin end
          else if (bus.op_valid) begin
            if (legal(int'(bus.op_sel))) begin
              m_a <= m_res % 16; m_op <= int'(bus.op_sel); m_b <= 0;
              m_bset <= 1'b0; m_rv <= 1'b0; m_ph <= PH_B;
            end
          end else if (bus.digit_valid) begin
            m_a <= int'(bus.digit); m_b <= 0; m_bset <= 1'b0;
            m_rv <= 1'b0; m_err <= 1'b0; m_ph <= PH_A;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("alu_op",       bus.alu_op,       exp_alu_op());
      chk("alu_data1",    bus.alu_data1,    m_a);
      chk("alu_data2",    bus.alu_data2,    m_b);
      chk("result",       bus.result,       m_res);
      chk("result_valid", bus.result_valid, m_rv);
      chk("err",          bus.err,          m_err);
      chk("seq_busy",     bus.seq_busy,     m_ph == PH_CALC);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    bus.op_valid    = 1'b0;
    bus.eq_valid    = 1'b0;
    bus.clr_valid   = 1'b0;
  endtask

  task automatic key_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1; bus.digit = d; cyc();
  endtask

  task automatic key_op(input logic [3:0] o);
    bus.op_valid = 1'b1; bus.op_sel = o; cyc();
  endtask

  task automatic key_eq();
    bus.eq_valid = 1'b1; cyc();
  endtask

  task automatic key_clr();
    bus.clr_valid = 1'b1; cyc();
  endtask

  task automatic wait_settle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.seq_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("settle_seq_busy", bus.seq_busy, 1'b0);
  endtask

  int s_cnt, s_st;

  initial begin
    rst = 1'b1;
    bus.digit_valid = 1'b0; bus.digit = 4'd0;
    bus.op_valid = 1'b0; bus.op_sel = 4'd0;
    bus.eq_valid = 1'b0; bus.clr_valid = 1'b0;
    alu_dead = 1'b0; alu_len = 9;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_result", bus.result, 8'h00);
    chk("rst_rv", bus.result_valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_busy", bus.seq_busy, 1'b0);
    chk("rst_alu_op", bus.alu_op, 4'b0000);

    // 3 + 4
    s_cnt = cnt_add;
    key_digit(4'd3); key_op(4'b1000); key_digit(4'd4); key_eq();
    cyc(); @(negedge clk);
    chk("add_rv_early", bus.result_valid, 1'b0);
    cyc(); @(negedge clk);
    chk("add_rv", bus.result_valid, 1'b1);
    chk("add_result", bus.result, 8'h07);
    chk("add_op_cycles", cnt_add - s_cnt, 1);

    // 7 / 0
    key_clr();
    s_cnt = cnt_div;
    key_digit(4'd7); key_op(4'b0001); key_digit(4'd0); key_eq();
    @(negedge clk);
    chk("div0_err", bus.err, 1'b1);
    chk("div0_rv", bus.result_valid, 1'b0);
    repeat (3) cyc();
    chk("div0_no_issue", cnt_div - s_cnt, 0);

    // mul with dead ALU
    key_clr();
    alu_dead = 1'b1; s_st = alu_starts;
    key_digit(4'd2); key_op(4'b0010); key_digit(4'd3); key_eq();
    repeat (3) cyc();
    @(negedge clk);
    chk("tmo_err_early", bus.err, 1'b0);
    chk("tmo_alu_op_whi", bus.alu_op, 4'b0010);
    cyc(); @(negedge clk);
    chk("tmo_err", bus.err, 1'b1);
    chk("tmo_rv", bus.result_valid, 1'b0);
    chk("tmo_alu_op", bus.alu_op, 4'b0000);
    alu_dead = 1'b0;

    // 2 x 3 with 9 busy cycles
    key_clr();
    s_cnt = cnt_mul; s_st = alu_starts;
    key_digit(4'd2); key_op(4'b0010); key_digit(4'd3); key_eq();
    wait_settle(40);
    chk("mul_result", bus.result, 8'h06);
    chk("mul_rv", bus.result_valid, 1'b1);
    chk("mul_op_cycles", cnt_mul - s_cnt, 10);
    repeat (4) cyc();
    chk("mul_starts", alu_starts - s_st, 1);

    // chain: 6 + 1
    key_op(4'b1000);
    @(negedge clk);
    chk("chain_a", bus.alu_data1, 4'd6);
    chk("chain_rv", bus.result_valid, 1'b0);
    key_digit(4'd1); key_eq();
    wait_settle(10);
    chk("chain_result", bus.result, 8'h07);

    // clr beats eq in S_B
    key_digit(4'd5); key_op(4'b1000); key_digit(4'd6);
    bus.clr_valid = 1'b1; bus.eq_valid = 1'b1; cyc();
    @(negedge clk);
    chk("clreq_a", bus.alu_data1, 4'd0);
    chk("clreq_b", bus.alu_data2, 4'd0);
    chk("clreq_result", bus.result, 8'h00);
    chk("clreq_busy", bus.seq_busy, 1'b0);

    // op beats digit in S_A, then 0 - 2
    bus.digit_valid = 1'b1; bus.digit = 4'd9;
    bus.op_valid = 1'b1; bus.op_sel = 4'b0100; cyc();
    key_digit(4'd2); key_eq();
    @(negedge clk);
    chk("dop_a", bus.alu_data1, 4'd0);
    chk("dop_alu_op", bus.alu_op, 4'b0100);
    wait_settle(10);
    chk("sub_result", bus.result, 8'hFE);

    // rst during S_WLO
    alu_len = 9;
    key_digit(4'd2); key_op(4'b0010); key_digit(4'd3); key_eq();
    repeat (3) cyc();
    @(negedge clk);
    chk("wlo_busy", bus.seq_busy, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_result", bus.result, 8'h00);
    chk("mid_rst_rv", bus.result_valid, 1'b0);
    chk("mid_rst_busy", bus.seq_busy, 1'b0);
    chk("mid_rst_alu_op", bus.alu_op, 4'b0000);

    // random key traffic
    for (int it = 0; it < 4000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      alu_dead = ($urandom_range(0, 9) == 0);
      alu_len  = $urandom_range(1, 9);
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      if (r < 3) begin
        bus.clr_valid = 1'b1;
        bus.eq_valid  = 1'($urandom_range(0, 1));
      end else if (r < 33) begin
        bus.digit_valid = 1'b1;
        bus.digit = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      end else if (r < 50) begin
        bus.op_valid = 1'b1;
        bus.op_sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      end else if (r < 60) begin
        bus.eq_valid = 1'b1;
      end else if (r < 64) begin
        bus.digit_valid = 1'b1; bus.digit = 4'($urandom);
        bus.op_valid = 1'b1; bus.op_sel = 4'b0001 << $urandom_range(0, 3);
      end
      cyc();
      rst = 1'b0;
    end
    repeat (20) cyc();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port digit_valid, input, 1 bit: one-cycle strobe; digit holds a valid operand.
REQ-004 SHALL have port digit, input, 4 bits: operand value, unsigned pattern passed unchanged to the ALU.
REQ-005 SHALL have port op_valid, input, 1 bit: one-cycle strobe; op_sel holds a valid operator.
REQ-006 SHALL have port op_sel, input, 4 bits: 1000 add, 0100 sub, 0010 mul, 0001 div; any other code is ignored.
REQ-007 SHALL have port eq_valid, input, 1 bit: one-cycle "=" strobe.
REQ-008 SHALL have port clr_valid, input, 1 bit: one-cycle clear strobe.
REQ-009 SHALL have port alu_op, output, 4 bits: operator to the ALU; 0000 means STOP.
REQ-010 SHALL have ports alu_data1 and alu_data2, output, 4 bits each: operands A and B to the ALU.
REQ-011 SHALL have port alu_busy, input, 1 bit: ALU busy flag.
REQ-012 SHALL have port alu_o, input, 8 bits: ALU result.
REQ-013 SHALL have port result, output, 8 bits: captured ALU result.
REQ-014 SHALL have port result_valid, output, 1 bit: level; result is valid.
REQ-015 SHALL have port err, output, 1 bit: level; the last operation was aborted.
REQ-016 SHALL have port seq_busy, output, 1 bit: level; a calculation is in flight and keys are ignored.

Function
REQ-017 SHALL implement states S_A, S_B, S_ISSUE, S_CAP, S_WHI, S_WLO and S_DONE, with registers A, B, OP (4 bits each) and RES (8 bits).
REQ-018 SHALL, when strobes coincide in one cycle, act on exactly one using priority clr > eq > op > digit.
REQ-019 SHALL, on clr_valid in any state, go to S_A, zero A/B/OP/RES and clear result_valid and err.
REQ-020 SHALL behave as follows in S_A:
- digit_valid: A <= digit; a later digit overwrites it.
- op_valid with a legal code: OP <= op_sel, go to S_B.
- eq_valid: ignored.
REQ-021 SHALL behave as follows in S_B:
- digit_valid: B <= digit and mark B as entered.
- op_valid with a legal code: replace OP.
- eq_valid with no B entered: ignored.
REQ-022 SHALL, on eq_valid in S_B with B entered:
- if OP = 0001 and B = 0: set err, go to S_DONE with result_valid = 0 and never issue to the ALU;
- otherwise go to S_ISSUE.
REQ-023 SHALL drive alu_data1 = A and alu_data2 = B at all times.
REQ-024 SHALL drive alu_op = OP in S_ISSUE and S_WHI, and in S_WLO while alu_busy = 1; otherwise 0000.
REQ-025 SHALL derive alu_op combinationally, so that the cycle in S_WLO with alu_busy = 0 already shows 0000 and the ALU cannot restart.
REQ-026 SHALL spend exactly one cycle in S_ISSUE, then:
- add/sub: go to S_CAP;
- mul/div: go to S_WHI.
REQ-027 SHALL, in S_CAP (alu_op = 0000), load RES <= alu_o at the cycle end, set result_valid and go to S_DONE; add/sub latency from eq_valid to result_valid is 3 cycles.
REQ-028 SHALL, in S_WHI, go to S_WLO on alu_busy = 1.
REQ-029 SHALL keep a 2-bit timeout counter in S_WHI; if alu_busy stays 0 for 3 consecutive cycles there, set err and go to S_DONE with result_valid = 0.
REQ-030 SHALL, in S_WLO on the first cycle with alu_busy = 0, load RES <= alu_o, set result_valid and go to S_DONE; there is no timeout in S_WLO.
REQ-031 SHALL drive seq_busy = 1 exactly in S_ISSUE, S_CAP, S_WHI and S_WLO, and ignore digit, op and eq strobes in those states (clr still acts).
REQ-032 SHALL behave as follows in S_DONE:
- digit_valid: clear result_valid and err, A <= digit, B cleared, go to S_A.
- op_valid with a legal code: chain, i.e. A <= RES[3:0], OP <= op_sel, clear result_valid and B, go to S_B.
- eq_valid: ignored.
REQ-033 SHALL drive result = RES at all times; RES changes only on capture or clear.

Reset
REQ-034 SHALL, on rst = 1 at a rising edge, enter S_A with A = B = OP = 0 and RES = 0.
REQ-035 SHALL hold these outputs after reset: result = 0, result_valid = 0, err = 0, seq_busy = 0, and alu_op = 0000 combinationally.
REQ-036 SHALL give rst priority over all strobes and abort any in-flight operation, including mid-S_WLO, with no result capture.

Verification
REQ-037 SHALL cover add: digit 3, op 1000, digit 4, eq -> alu_op = 1000 for exactly 1 cycle; result = alu_o (0x07 from ALU model), result_valid 3 cycles after eq.
REQ-038 SHALL cover mul handshake: 2 x 3 with an ALU model asserting busy for 9 cycles -> alu_op = 0010 until busy falls; 0000 in the falling cycle; result = 0x06; no ALU restart.
REQ-039 SHALL cover divide by zero: digit 7, op 0001, digit 0, eq -> err = 1, result_valid = 0, alu_op never 0001.
REQ-040 SHALL cover busy timeout: mul issued, ALU model never asserts busy -> err = 1 after 3 cycles in S_WHI; alu_op returns to 0000.
REQ-041 SHALL cover simultaneous strobes: clr_valid with eq_valid in S_B -> S_A, all registers 0; separately digit and op together in S_A -> only op taken.
REQ-042 SHALL cover reset mid-operation and chaining:
- rst during S_WLO -> next cycle all outputs at reset values, alu_op = 0000;
- result 0x06 in S_DONE, then op 1000, digit 1, eq -> A = 6, result = 0x07.
